// File: rtl/spawn_rng_sched_pkg.sv
// Shared game parameters, field layout and FSM encodings for the spawn scheduler.
package spawn_rng_sched_pkg;

    localparam int unsigned COLS    = 10;
    localparam int unsigned X_W     = 4;
    localparam int unsigned K_W     = 2;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned MIN_GAP = 8;
    localparam int unsigned WORD_W  = X_W + K_W + GAP_W;
    // One spare bit keeps MIN_GAP + max gap representable without wrap.
    localparam int unsigned TMR_W   = $clog2(MIN_GAP + 2**GAP_W) + 1;

    // FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OFFER = 2'd3;

    // Produce-kind encodings
    localparam logic [K_W-1:0] KIND_APPLE = 2'd0;
    localparam logic [K_W-1:0] KIND_PEAR  = 2'd1;
    localparam logic [K_W-1:0] KIND_PLUM  = 2'd2;
    localparam logic [K_W-1:0] KIND_GOLD  = 2'd3;

    // Random word layout: first received bit lands in gap MSB, last in x LSB.
    typedef struct packed {
        logic [GAP_W-1:0] gap;
        logic [K_W-1:0]   kind;
        logic [X_W-1:0]   x;
    } spawn_word_t;

endpackage

// File: rtl/spawn_rng_sched_deser.sv
// Deserialiser: shifts the random stream every cycle and flags each full word while running.
module rng_deser #(
    parameter int unsigned WORD_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rnd_bit,
    input  logic              run,
    output logic [WORD_W-1:0] word_c,
    output logic              word_done_c
);
    localparam int unsigned CNT_W = $clog2(WORD_W);

    // Only WORD_W-1 history bits are needed; the newest bit comes straight from the input.
    logic [WORD_W-2:0] sh;
    logic [CNT_W-1:0]  cnt;

    assign word_c      = {sh, rnd_bit};
    assign word_done_c = run && (cnt == CNT_W'(WORD_W - 1));

    // Shift every cycle; count fresh bits only while running, restart after each word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh  <= word_c[WORD_W-2:0];
            cnt <= (run && !word_done_c) ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/spawn_rng_sched.sv
// Spawn scheduler: turns random words into gapped spawn offers on a valid/ready handshake.
module spawn_rng_sched
    import spawn_rng_sched_pkg::*;
(
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    input  logic           rnd_bit,
    input  logic           spawn_ready,
    output logic           spawn_valid,
    output logic [X_W-1:0] spawn_x,
    output logic [K_W-1:0] spawn_kind,
    output logic [7:0]     spawn_cnt
);
    logic [1:0]        state, state_d;
    logic [TMR_W-1:0]  timer, timer_d;
    logic              valid_d;
    logic [X_W-1:0]    x_d;
    logic [K_W-1:0]    kind_d;
    logic [7:0]        cnt_d;
    logic [WORD_W-1:0] word_c;
    logic              word_done_c;
    spawn_word_t       w;

    assign w = spawn_word_t'(word_c);

    rng_deser #(.WORD_W(WORD_W)) u_deser (
        .clk         (clk),
        .clr         (clr),
        .rnd_bit     (rnd_bit),
        .run         (state == ST_FILL),
        .word_c      (word_c),
        .word_done_c (word_done_c)
    );

    // State, timer and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= ST_IDLE;
            timer       <= '0;
            spawn_valid <= 1'b0;
            spawn_x     <= '0;
            spawn_kind  <= '0;
            spawn_cnt   <= '0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            spawn_valid <= valid_d;
            spawn_x     <= x_d;
            spawn_kind  <= kind_d;
            spawn_cnt   <= cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        timer_d = timer;
        valid_d = spawn_valid;
        x_d     = spawn_x;
        kind_d  = spawn_kind;
        cnt_d   = spawn_cnt;
        case (state)
            ST_IDLE: begin
                if (en) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (word_done_c && (w.x < X_W'(COLS))) begin
                    x_d     = w.x;
                    kind_d  = w.kind;
                    timer_d = TMR_W'(MIN_GAP) + TMR_W'(w.gap);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (timer == TMR_W'(1)) begin
                    timer_d = '0;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end else begin
                    timer_d = timer - TMR_W'(1);
                end
            end
            ST_OFFER: begin
                // The offer is held regardless of en until the consumer takes it.
                if (spawn_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = spawn_cnt + 8'd1;
                    state_d = en ? ST_FILL : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spawn_rng_sched.sv
// Scoreboard bench for spawn_rng_sched: a cycle model predicts offers, the monitor checks the DUT.
module tb_spawn_rng_sched;
    import spawn_rng_sched_pkg::*;

    logic           clk = 1'b0;
    logic           clr;
    logic           en;
    logic           rnd_bit;
    logic           spawn_ready;
    logic           spawn_valid;
    logic [X_W-1:0] spawn_x;
    logic [K_W-1:0] spawn_kind;
    logic [7:0]     spawn_cnt;

    always #5 clk = ~clk;

    spawn_rng_sched dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .rnd_bit     (rnd_bit),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_kind  (spawn_kind),
        .spawn_cnt   (spawn_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d @%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state (0 idle, 1 fill, 2 wait, 3 offer)
    int          m_st, m_bits, m_tmr, m_cnt, acc;
    int unsigned m_word;
    logic [5:0]  sb[$];
    logic [3:0]  cur_x;
    logic [1:0]  cur_k;
    logic        prev_valid;

    task automatic model_reset();
        m_st = 0; m_bits = 0; m_tmr = 0; m_cnt = 0; acc = 0;
        m_word = 0; sb.delete(); prev_valid = 1'b0; cur_x = '0; cur_k = '0;
    endtask

    // Predict what the coming rising edge does, from the inputs now applied.
    task automatic model_edge();
        case (m_st)
            0: if (en) begin m_st = 1; m_bits = 0; m_word = 0; end
            1: if (!en) m_st = 0;
               else begin
                   m_word = ((m_word << 1) | 32'(rnd_bit)) & 32'h3FF;
                   m_bits++;
                   if (m_bits == 10) begin
                       m_bits = 0;
                       if ((m_word & 15) < 10) begin
                           sb.push_back({4'(m_word & 15), 2'((m_word >> 4) & 3)});
                           m_tmr = 8 + int'((m_word >> 6) & 15);
                           m_st  = 2;
                       end
                   end
               end
            2: if (!en) begin
                   m_st = 0;
                   if (sb.size() > 0) sb.delete(sb.size() - 1);
               end else begin
                   m_tmr--;
                   if (m_tmr == 0) m_st = 3;
               end
            default: if (spawn_ready) begin
                   m_cnt = (m_cnt + 1) % 256;
                   m_st  = en ? 1 : 0;
                   m_bits = 0; m_word = 0;
               end
        endcase
    endtask

    task automatic monitor();
        check("valid", spawn_valid, (m_st == 3));
        check("cnt", spawn_cnt, m_cnt);
        if (spawn_valid && !prev_valid) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) {cur_x, cur_k} = sb.pop_front();
        end
        if (spawn_valid) begin
            check("x", spawn_x, cur_x);
            check("kind", spawn_kind, cur_k);
            check("x_range", (spawn_x < COLS), 1);
        end
        prev_valid = spawn_valid;
    endtask

    // Inputs are set at the falling edge; outputs are checked at the next falling edge.
    task automatic tick();
        if (spawn_valid && spawn_ready) acc++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic feed_word(input logic [9:0] wv);
        for (int i = 9; i >= 0; i--) begin
            rnd_bit = wv[i];
            tick();
        end
        rnd_bit = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!spawn_valid && n < maxc) begin
            tick();
            n++;
        end
        check("wait_timeout", spawn_valid, 1);
    endtask

    int         n;
    logic [7:0] lfsr;

    initial begin
        clr = 1'b0; en = 1'b0; rnd_bit = 1'b0; spawn_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", spawn_valid, 0);
        check("rst_x", spawn_x, 0);
        check("rst_kind", spawn_kind, 0);
        check("rst_cnt", spawn_cnt, 0);
        clr = 1'b1;
        repeat (2) tick();

        // Directed word: x=3 kind=1 gap=3 -> 10 fill + 11 wait
        en = 1'b1;
        tick();
        feed_word(10'b0011_01_0011);
        wait_valid(50, n);
        check("dir_lat", n, 11);
        check("dir_x", spawn_x, 3);
        check("dir_kind", spawn_kind, 1);

        // Backpressure: offer stays stable while ready is low
        repeat (5) tick();
        check("bp_hold", spawn_valid, 1);
        check("bp_x", spawn_x, 3);
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;
        check("bp_cnt", spawn_cnt, 1);
        check("bp_valid", spawn_valid, 0);

        // Rejections at x=10 and x=12, then x=5 kind=2 gap=2
        feed_word(10'b0000_00_1010);
        check("rej10_novalid", spawn_valid, 0);
        feed_word(10'b0000_00_1100);
        check("rej12_novalid", spawn_valid, 0);
        feed_word(10'b0010_10_0101);
        wait_valid(50, n);
        check("rej_lat", n, 10);
        check("rej_x", spawn_x, 5);
        check("rej_kind", spawn_kind, 2);

        // en dropped during an offer: held until taken, then idle
        en = 1'b0;
        repeat (3) tick();
        check("offer_held", spawn_valid, 1);
        spawn_ready = 1'b1;
        tick();
        spawn_ready = 1'b0;
        check("offer_acc", spawn_valid, 0);
        check("offer_cnt", spawn_cnt, 2);
        for (int i = 0; i < 12; i++) begin
            rnd_bit = i[0];
            tick();
        end
        check("idle_novalid", spawn_valid, 0);

        // en dropped during the wait: spawn discarded
        en = 1'b1; rnd_bit = 1'b0;
        tick();
        feed_word(10'b0101_11_0111);
        repeat (3) tick();
        en = 1'b0;
        repeat (30) tick();
        check("wait_abort", spawn_valid, 0);

        // Async clear while offering the boundary column x=9
        en = 1'b1;
        tick();
        feed_word(10'b0001_00_1001);
        wait_valid(50, n);
        check("b9_x", spawn_x, 9);
        clr = 1'b0;
        #1;
        check("clr_valid", spawn_valid, 0);
        check("clr_x", spawn_x, 0);
        check("clr_kind", spawn_kind, 0);
        check("clr_cnt", spawn_cnt, 0);
        model_reset();
        @(negedge clk);
        en = 1'b0;
        clr = 1'b1;
        repeat (5) tick();
        check("post_clr_idle", spawn_valid, 0);

        // System run from the LFSR with random backpressure
        lfsr = 8'hA5;
        en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            rnd_bit = lfsr[7];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            spawn_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        spawn_ready = 1'b0;
        check("sys_cnt", spawn_cnt, acc % 256);
        check("sys_activity", (acc > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
